// File: rtl/tick_gen_multi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen_multi_pkg : shared clock and standard divisor constants   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package tick_gen_multi_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int CNT_W_DEF   = 27;

  localparam int DIV_1HZ     = CLK_HZ;
  localparam int DIV_2HZ     = CLK_HZ / 2;
  localparam int DIV_4HZ     = CLK_HZ / 4;
  localparam int DIV_REFRESH = 400_000;

endpackage : tick_gen_multi_pkg
`default_nettype wire

// File: rtl/tick_gen_multi_tick_chan.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_chan : one divider channel with tick pulse and square output  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_chan
  import tick_gen_multi_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             tick_o,
  output logic             square_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic             square_q, square_d;

  always_comb begin
    cnt_d    = cnt_q;
    div_d    = div_q;
    tick_d   = 1'b0;
    square_d = square_q;

    if (clr_i) begin
      cnt_d    = '0;
      square_d = 1'b0;
    end

    // A load still applies under clear, and pre-empts a coincident terminal count.
    if (load_i) begin
      div_d = (load_val_i == '0) ? CNT_W'(1) : load_val_i;
      cnt_d = '0;
    end else if (!clr_i && en_i) begin
      if (cnt_q == div_q - CNT_W'(1)) begin
        cnt_d    = '0;
        tick_d   = 1'b1;
        square_d = ~square_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      div_q    <= DIV_RST;
      tick_q   <= 1'b0;
      square_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      square_q <= square_d;
    end
  end

  assign tick_o   = tick_q;
  assign square_o = square_q;

endmodule : tick_chan
`default_nettype wire

// File: rtl/tick_gen_multi.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tick_gen_multi : NUM_CH independent tick / square-wave generators  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tick_gen_multi
  import tick_gen_multi_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {CNT_W'(DIV_4HZ), CNT_W'(DIV_REFRESH),
                                                 CNT_W'(DIV_1HZ), CNT_W'(DIV_2HZ)}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              div_load,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] square
);

  // Indices at or above NUM_CH match no channel, so such loads are dropped.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    logic load_sel;
    assign load_sel = div_load && (div_ch == 3'(gi));

    tick_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[gi*CNT_W +: CNT_W])
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .en_i       (ch_en[gi]),
      .clr_i      (sync_clr),
      .load_i     (load_sel),
      .load_val_i (div_val),
      .tick_o     (tick[gi]),
      .square_o   (square[gi])
    );
  end

endmodule : tick_gen_multi
`default_nettype wire
